// File: rtl/freq_meter_defs.sv
// Shared constants for the frequency meter: FSM encoding, parameter defaults
// and the width of the published edge count.
package freq_meter_defs;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LATCH   = 2'd2
   } state_t;

   localparam int DEF_GATE_CYCLES = 100_000_000;
   localparam int DEF_MAX_COUNT   = 9999;
   localparam int FREQ_W          = 14;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector; rise is a one-cycle pulse 3 clk edges after d rises.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
      prev_d = sync_q;
      rise_d = sync_q & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in over a window of
// GATE_CYCLES clocks and publishes the (saturating) count with a valid pulse.
module freq_meter
   import freq_meter_defs::*;
#(
   parameter int GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int MAX_COUNT   = DEF_MAX_COUNT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sig_in,
   output logic [FREQ_W-1:0] freq,
   output logic              overflow,
   output logic              valid,
   output logic              busy
);

   localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [FREQ_W-1:0] MAX_C     = FREQ_W'(MAX_COUNT);

   state_t            state_q, state_d;
   logic [GW-1:0]     gate_cnt_q, gate_cnt_d;
   logic [FREQ_W-1:0] edge_cnt_q, edge_cnt_d;
   logic              ovf_q, ovf_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic              overflow_q, overflow_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              edge_pulse;

   sync_edge_det u_sync_edge_det (
      .clk  (clk),
      .rst  (rst),
      .d    (sig_in),
      .rise (edge_pulse)
   );

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      ovf_d      = ovf_q;
      freq_d     = freq_q;
      overflow_d = overflow_q;
      valid_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
            if (en) begin
               state_d = ST_MEASURE;
            end
         end

         ST_MEASURE: begin
            if (!en) begin
               // Abort: drop the partial window, published result untouched.
               state_d    = ST_IDLE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               ovf_d      = 1'b0;
            end else begin
               gate_cnt_d = gate_cnt_q + GW'(1);
               if (edge_pulse) begin
                  if (edge_cnt_q == MAX_C) begin
                     ovf_d = 1'b1;
                  end else begin
                     edge_cnt_d = edge_cnt_q + FREQ_W'(1);
                  end
               end
               // Final gate cycle still counts its edge; the counter is parked
               // at 0 so it cannot wrap when GATE_CYCLES is a power of two.
               if (gate_cnt_q == GATE_LAST) begin
                  state_d    = ST_LATCH;
                  gate_cnt_d = '0;
               end
            end
         end

         ST_LATCH: begin
            freq_d     = edge_cnt_q;
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
            state_d    = en ? ST_MEASURE : ST_IDLE;
         end

         default: begin
            state_d    = ST_IDLE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         ovf_q      <= 1'b0;
         freq_q     <= '0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         ovf_q      <= ovf_d;
         freq_q     <= freq_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
      end
   end

   assign freq     = freq_q;
   assign overflow = overflow_q;
   assign valid    = valid_q;
   assign busy     = busy_q;

endmodule
